cycle_sequencer: RTL and testbench

Instruction-cycle controller for the teaching CPU. It generates the one-cycle `Go` strobe that advances the CPU datapath. It supports three operating modes:
- free-running at a slow or turbo rate,
- single-step driven by a push button,
- halted on CPU request, left by a resume button.

It replaces the free-running divider inside the CPU top level. It sits between the board inputs (Turbo switch, buttons) and the CPU instruction-cycle block.

---
 rtl/cycle_sequencer_pkg.sv | 15 +
 rtl/cycle_sequencer_edge_pulse.sv | 29 ++
 rtl/cycle_sequencer.sv | 122 ++++++++++++
 tb/tb_cycle_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding
// (also shown on the debug LEDs) and default divider constants.
package cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_STEP = 2'b01,
    ST_HALT = 2'b10
  } seq_state_t;

  localparam int DEFAULT_SLOW_MAX  = 15;
  localparam int DEFAULT_FAST_MAX  = 3;
  localparam int DEFAULT_CNT_WIDTH = 24;

endpackage

// File: rtl/cycle_sequencer_edge_pulse.sv
// Two-flop synchroniser plus history flop that turns a raw, already
// debounced button level into a single-cycle pulse per press.
module cycle_sequencer_edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic sync_a;
  logic sync_b;
  logic hist;

  // Bring the button into the clock domain and remember the previous level
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      hist   <= sync_b;
    end
  end

  assign pulse = sync_b & ~hist;

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle controller: produces the one-cycle Go strobe for the CPU
// in free-running, single-step or halted operation.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int SlowMax  = DEFAULT_SLOW_MAX,
  parameter int FastMax  = DEFAULT_FAST_MAX,
  parameter int CntWidth = DEFAULT_CNT_WIDTH
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Turbo,
  input  logic       StepMode,
  input  logic       StepBtn,
  input  logic       ResumeBtn,
  input  logic       Halt,
  output logic       Go,
  output logic [1:0] State,
  output logic [7:0] CycleCount
);

  localparam logic [CntWidth-1:0] SLOW_MAX_C = CntWidth'(SlowMax);
  localparam logic [CntWidth-1:0] FAST_MAX_C = CntWidth'(FastMax);

  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_next;
  logic [CntWidth-1:0] max_sel;
  logic                tick;
  logic                step_pulse;
  logic                resume_pulse;
  logic                go;
  logic [7:0]          cycle_count;
  seq_state_t          state;

  cycle_sequencer_edge_pulse u_step_pulse (
    .clock (Clock),
    .reset (Reset),
    .raw   (StepBtn),
    .pulse (step_pulse)
  );

  cycle_sequencer_edge_pulse u_resume_pulse (
    .clock (Clock),
    .reset (Reset),
    .raw   (ResumeBtn),
    .pulse (resume_pulse)
  );

  // Next divider value; >= makes a count above a freshly lowered limit wrap at once
  always_comb begin
    max_sel  = Turbo ? FAST_MAX_C : SLOW_MAX_C;
    cnt_next = (cnt >= max_sel) ? '0 : cnt + CntWidth'(1);
    tick     = (cnt_next == '0);
  end

  // Divider register, free-running in every state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= CntWidth'(1);
    end else begin
      cnt <= cnt_next;
    end
  end

  // Mode FSM with registered Go; Go is never allowed two cycles in a row
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_RUN;
      go          <= 1'b0;
      cycle_count <= 8'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (Halt && !go) begin
            state <= ST_HALT;
            go    <= 1'b0;
          end else if (StepMode) begin
            state <= ST_STEP;
            go    <= 1'b0;
          end else begin
            go <= tick && !go;
            if (tick && !go) begin
              cycle_count <= cycle_count + 8'd1;
            end
          end
        end
        ST_STEP: begin
          if (Halt && !go) begin
            state <= ST_HALT;
            go    <= 1'b0;
          end else begin
            go <= step_pulse && !go;
            if (step_pulse && !go) begin
              cycle_count <= cycle_count + 8'd1;
            end
            if (!StepMode) begin
              state <= ST_RUN;
            end
          end
        end
        ST_HALT: begin
          if (resume_pulse) begin
            go          <= 1'b1;
            cycle_count <= cycle_count + 8'd1;
            state       <= StepMode ? ST_STEP : ST_RUN;
          end else begin
            go <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
          go    <= 1'b0;
        end
      endcase
    end
  end

  assign Go         = go;
  assign State      = state;
  assign CycleCount = cycle_count;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: walks through RUN, turbo change,
// single-step, halt/resume, simultaneous buttons and reset during activity.
module tb_cycle_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Turbo;
  logic       StepMode;
  logic       StepBtn;
  logic       ResumeBtn;
  logic       Halt;
  logic       Go;
  logic [1:0] State;
  logic [7:0] CycleCount;

  int total_checks = 0;
  int bad_checks   = 0;

  cycle_sequencer #(
    .SlowMax  (15),
    .FastMax  (3),
    .CntWidth (24)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Turbo      (Turbo),
    .StepMode   (StepMode),
    .StepBtn    (StepBtn),
    .ResumeBtn  (ResumeBtn),
    .Halt       (Halt),
    .Go         (Go),
    .State      (State),
    .CycleCount (CycleCount)
  );

  // 10 ns system clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    if (observed != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic turbo, input logic step_mode,
                               input logic step_btn, input logic resume_btn,
                               input logic halt);
    Turbo     = turbo;
    StepMode  = step_mode;
    StepBtn   = step_btn;
    ResumeBtn = resume_btn;
    Halt      = halt;
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Count Go pulses seen over n edges; also report the edge of the first one
  task automatic countGos(input int n, output int gos, output int first_at);
    gos      = 0;
    first_at = 0;
    for (int i = 1; i <= n; i++) begin
      waitCycles(1);
      if (Go) begin
        gos++;
        if (first_at == 0) first_at = i;
      end
    end
  endtask

  int gos;
  int first_at;

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("rst_state", State, 0);
    checkOutput("rst_go", Go, 0);
    checkOutput("rst_count", CycleCount, 0);

    // Slow free-run: first Go after edge 15, then every 16 edges
    Reset = 1'b0;
    waitCycles(14);
    checkOutput("t1_no_go_e14", Go, 0);
    waitCycles(1);
    checkOutput("t1_go_e15", Go, 1);
    checkOutput("t1_count1", CycleCount, 1);
    waitCycles(1);
    checkOutput("t1_go_drop_e16", Go, 0);
    waitCycles(14);
    checkOutput("t1_no_go_e30", Go, 0);
    waitCycles(1);
    checkOutput("t1_go_e31", Go, 1);
    waitCycles(16);
    checkOutput("t1_go_e47", Go, 1);
    checkOutput("t1_count3", CycleCount, 3);

    // Turbo raised with cnt=10: immediate wrap, then period 4
    waitCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t2_wrap_go", Go, 1);
    checkOutput("t2_count4", CycleCount, 4);
    waitCycles(1);
    checkOutput("t2_no_double", Go, 0);
    waitCycles(2);
    checkOutput("t2_no_go_e61", Go, 0);
    waitCycles(1);
    checkOutput("t2_go_e62", Go, 1);
    countGos(40, gos, first_at);
    checkOutput("t2_gos_40", gos, 10);
    checkOutput("t2_count15", CycleCount, 15);

    // Single step with the button held for 50 cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t3_state_step", State, 1);
    checkOutput("t3_go_entry", Go, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    countGos(50, gos, first_at);
    checkOutput("t3_one_go", gos, 1);
    checkOutput("t3_go_latency", first_at, 3);
    checkOutput("t3_state", State, 1);
    checkOutput("t3_count16", CycleCount, 16);

    // Back to RUN, then Halt, 100 idle cycles, resume
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t4_state_run", State, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("t4_state_halt", State, 2);
    countGos(100, gos, first_at);
    checkOutput("t4_halt_no_go", gos, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(2);
    checkOutput("t4_resume_wait", Go, 0);
    waitCycles(1);
    checkOutput("t4_resume_go", Go, 1);
    checkOutput("t4_resume_state", State, 0);
    checkOutput("t4_count17", CycleCount, 17);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    countGos(32, gos, first_at);
    checkOutput("t4_ticking_gos", gos, 2);
    checkOutput("t4_ticking_first", first_at, 4);
    checkOutput("t4_count19", CycleCount, 19);

    // Halted with step and resume rising together, StepMode=1
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("t5_state_halt", State, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    waitCycles(2);
    checkOutput("t5_wait_go", Go, 0);
    waitCycles(1);
    checkOutput("t5_go", Go, 1);
    checkOutput("t5_state_step", State, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    countGos(10, gos, first_at);
    checkOutput("t5_step_lost", gos, 0);
    checkOutput("t5_state_hold", State, 1);
    checkOutput("t5_count20", CycleCount, 20);

    // Reset one cycle before a divider Go would fire
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t6_state_run", State, 0);
    waitCycles(4);
    checkOutput("t6_pre_go", Go, 0);
    Reset = 1'b1;
    waitCycles(1);
    checkOutput("t6_rst_go", Go, 0);
    checkOutput("t6_rst_state", State, 0);
    checkOutput("t6_rst_count", CycleCount, 0);
    Reset = 1'b0;
    countGos(14, gos, first_at);
    checkOutput("t6_no_early_go", gos, 0);
    waitCycles(1);
    checkOutput("t6_go_e15", Go, 1);

    // Reset while a resume pulse is in flight
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("t6_halt_state", State, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(2);
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t6_resume_rst_go", Go, 0);
    checkOutput("t6_resume_rst_state", State, 0);
    checkOutput("t6_resume_rst_count", CycleCount, 0);
    Reset = 1'b0;
    countGos(14, gos, first_at);
    checkOutput("t6_resume_rst_quiet", gos, 0);
    waitCycles(1);
    checkOutput("t6_resume_rst_go15", Go, 1);
    checkOutput("t6_resume_rst_count1", CycleCount, 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
